// File: rtl/ins_fetch_unit_pkg.sv
// ins_fetch_unit_pkg
//   Shared processor-side definitions for the instruction fetch path:
//   instruction/address widths, default reset and exception vectors, and
//   the {addr, data} word carried through the prefetch FIFO.
package ins_fetch_unit_pkg;

  localparam int INS_W  = 16;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC_DEF = 16'h0000;
  localparam logic [ADDR_W-1:0] EXCP_VEC_DEF = 16'h0004;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INS_W-1:0]  data;
  } fetch_word_t;

endpackage

// File: rtl/ins_fetch_unit_if.sv
// ins_fetch_unit_if
//   Bundles the program-ROM read bus and the instruction valid/ready
//   handshake toward decode.
//   master : fetch unit side (drives ROM request and instruction output)
//   slave  : environment side (ROM + decode consumer)
//   Signals:
//     mem_rd, mem_addr       ROM read strobe / address
//     mem_data               ROM data, one cycle after mem_rd
//     ins_out, ins_pc        instruction word at FIFO head and its address
//     ins_valid, ins_ready   handshake with the decode stage
interface ins_fetch_unit_if;
  import ins_fetch_unit_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [INS_W-1:0]  mem_data;
  logic [INS_W-1:0]  ins_out;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_valid;
  logic              ins_ready;

  modport master (
    output mem_rd, mem_addr, ins_out, ins_pc, ins_valid,
    input  mem_data, ins_ready
  );

  modport slave (
    input  mem_rd, mem_addr, ins_out, ins_pc, ins_valid,
    output mem_data, ins_ready
  );

endinterface

// File: rtl/ins_fetch_unit_fetch_fifo.sv
// fetch_fifo
//   Prefetch FIFO of {addr, data} words with a dedicated head register so
//   the output holds its last value once the FIFO drains.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     clr         flush all entries (head register keeps its value)
//     push        write push_word at the tail (caller guarantees room)
//     pop         remove the head entry (ignored when empty)
//     head        current head word
//     count       number of stored entries, 0..DEPTH
//     empty       count == 0
module fetch_fifo
  import ins_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  fetch_word_t       push_word,
  input  logic              pop,
  output fetch_word_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  fetch_word_t      mem [DEPTH];
  fetch_word_t      head_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic             pop_ok;

  assign rd_nxt = rd_ptr + PTR_W'(1);
  assign pop_ok = pop && (count != '0);
  assign empty  = (count == '0);
  assign head   = head_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_nxt;
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Head register tracks the entry at rd_ptr. With two or more entries the
  // successor is already in the array; with one entry a same-cycle push
  // becomes the new head. An empty FIFO leaves the last head in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
    end else if (!clr) begin
      if (pop_ok) begin
        if (count >= CNT_W'(2)) head_q <= mem[rd_nxt];
        else if (push)          head_q <= push_word;
      end else if (empty && push) begin
        head_q <= push_word;
      end
    end
  end

endmodule

// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit
//   Producer side of the 16-bit instruction path. Issues sequential reads
//   to a synchronous program ROM, buffers the returned words in a prefetch
//   FIFO and hands them to decode over a valid/ready handshake. Jumps and
//   exceptions flush the FIFO and drop the read still in flight.
//   Ports:
//     clk, rst    clock, synchronous active-high reset
//     bus         master side of ins_fetch_unit_if (ROM bus + ins handshake)
//     jmp         redirect pulse, target jmp_addr
//     excp        exception entry pulse (wins over jmp), target EXCP_VEC
//     excp_ret    return address captured on exception entry
module ins_fetch_unit
  import ins_fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] EXCP_VEC = EXCP_VEC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  ins_fetch_unit_if.master     bus,
  input  logic                 jmp,
  input  logic [ADDR_W-1:0]    jmp_addr,
  input  logic                 excp,
  output logic [ADDR_W-1:0]    excp_ret
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic [CNT_W:0]    occ;
  logic              flush;
  logic              issue;
  logic              push;
  logic              pop;
  fetch_word_t       push_word;
  fetch_word_t       head;
  logic [CNT_W-1:0]  count;
  logic              empty;

  assign flush = jmp || excp;

  // Stage 0: issue. Occupancy counts the word still coming back from the
  // ROM, so a granted read always has a FIFO slot waiting for it.
  assign occ          = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue        = !rst && !flush && (occ < (CNT_W+1)'(DEPTH));
  assign bus.mem_rd   = issue;
  assign bus.mem_addr = pc_q;

  // Stage 1: return. pc advanced on issue, so the in-flight read is pc-1.
  // A flush in the return cycle kills that word before it reaches the FIFO.
  assign rd_addr        = pc_q - ADDR_W'(1);
  assign push           = inflight_q && !flush && !rst;
  assign push_word.addr = rd_addr;
  assign push_word.data = bus.mem_data;

  // Oldest instruction not yet consumed: FIFO head, else the live in-flight
  // read (no issue happens in a flush cycle, so an in-flight read is never
  // one already killed), else the next fetch address.
  assign ret_addr = !empty     ? head.addr :
                    inflight_q ? rd_addr   : pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      excp_ret   <= '0;
    end else begin
      inflight_q <= issue;
      if (excp) begin
        pc_q     <= EXCP_VEC;
        excp_ret <= ret_addr;
      end else if (jmp) begin
        pc_q <= jmp_addr;
      end else if (issue) begin
        pc_q <= pc_q + ADDR_W'(1);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );

  // Stage 2: present head to decode.
  assign bus.ins_valid = !empty && !flush && !rst;
  assign bus.ins_out   = head.data;
  assign bus.ins_pc    = head.addr;
  assign pop           = bus.ins_valid && bus.ins_ready;

endmodule
